// File: rtl/fixed_square.sv
// Sequential shift-add squarer: unsigned Q8.8 operand in, saturated 8-bit integer square out.
// Define FIXED_SQUARE_ROUND_EN to round the result half up instead of truncating.
module fixed_square (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] in,
   output logic        busy,
   output logic        done,
   output logic [7:0]  out,
   output logic        ovf
);

   localparam int unsigned OP_W  = 16;
   localparam int unsigned ACC_W = 32;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned RES_W = 17;
   localparam int unsigned OUT_W = 8;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state_q, state_d;
   logic [OP_W-1:0]    op_q, op_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [OUT_W-1:0]   out_q, out_d;
   logic               ovf_q, ovf_d;
   logic [RES_W-1:0]   res_c;

   // Integer part of the Q16.16 product, one bit wider so a rounding carry can saturate.
   always_comb begin
`ifdef FIXED_SQUARE_ROUND_EN
      res_c = RES_W'(acc_q[31:16]) + RES_W'(acc_q[15]);
`else
      res_c = RES_W'(acc_q[31:16]);
`endif
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      out_d   = out_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            // A start coinciding with the done pulse is dropped.
            if (start && !done_q) begin
               op_d    = in;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (op_q[cnt_q]) begin
               acc_d = acc_q + (ACC_W'(op_q) << cnt_q);
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(15)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (res_c > RES_W'(255)) begin
               out_d = OUT_W'(255);
               ovf_d = 1'b1;
            end else begin
               out_d = res_c[OUT_W-1:0];
               ovf_d = 1'b0;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign out  = out_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_fixed_square.sv
// Directed-vector bench for fixed_square; expected results are hand-computed squares.
module tb_fixed_square;

`ifdef FIXED_SQUARE_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] in;
   logic        busy;
   logic        done;
   logic [7:0]  out;
   logic        ovf;

   int n_tot;
   int n_bad;

   fixed_square dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .in    (in),
      .busy  (busy),
      .done  (done),
      .out   (out),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; start is sampled at the next posedge.
   task automatic do_op(input string tag, input logic [15:0] val,
                        input logic [7:0] e_out, input logic e_ovf);
      int n;
      int busy_cnt;
      bit got;
      logic [7:0] held;
      start = 1'b1;
      in    = val;
      @(negedge clk);
      start    = 1'b0;
      n        = 0;
      busy_cnt = 0;
      got      = 1'b0;
      while (!got && n < 40) begin
         in = 16'($urandom);
         if (busy) busy_cnt++;
         if (done) got = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      chk({tag, "_lat"}, 32'(n), 32'd17);
      chk({tag, "_busy"}, 32'(busy_cnt), 32'd17);
      chk({tag, "_out"}, 32'(out), 32'(e_out));
      chk({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
      held = out;
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(done), 32'd0);
      chk({tag, "_hold"}, 32'(out), 32'(held));
   endtask

   initial begin
      int n;
      int dones;
      n_tot = 0;
      n_bad = 0;
      rst_n = 1'b0;
      start = 1'b0;
      in    = '0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      // First edge after release samples start.
      do_op("v2p5", 16'h0280, 8'd6, 1'b0);
      do_op("v0", 16'h0000, 8'd0, 1'b0);
      do_op("v1", 16'h0100, 8'd1, 1'b0);
      do_op("v1p5", 16'h0180, 8'd2, 1'b0);
      do_op("v0p5", 16'h0080, 8'd0, 1'b0);
      do_op("v181", 16'h00B5, 8'd0, 1'b0);
      do_op("v182", 16'h00B6, RND ? 8'd1 : 8'd0, 1'b0);
      do_op("v127", 16'h0B50, RND ? 8'd128 : 8'd127, 1'b0);
      do_op("v254", 16'h0FF0, 8'd254, 1'b0);
      do_op("v255", 16'h0FF8, 8'd255, 1'b0);
      do_op("v4092", 16'h0FFC, 8'd255, RND);
      do_op("v256", 16'h1000, 8'd255, 1'b1);
      do_op("vmax", 16'hFFFF, 8'd255, 1'b1);
      do_op("v15", 16'h0F00, 8'd225, 1'b0);

      // Start held high through CALC and the done cycle.
      start = 1'b1;
      in    = 16'h0F00;
      @(negedge clk);
      in    = 16'h0100;
      n     = 0;
      dones = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("hold_lat", 32'(n), 32'd17);
      chk("hold_out", 32'(out), 32'd225);
      @(negedge clk);
      chk("hold_ign", 32'(busy), 32'd0);
      @(negedge clk);
      chk("hold_acc", 32'(busy), 32'd1);
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("hold_out2", 32'(out), 32'd1);
      @(negedge clk);

      // Reset during CALC aborts the operation.
      start = 1'b1;
      in    = 16'h0500;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      chk("abort_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_out", 32'(out), 32'd0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      chk("abort_nodone", 32'(dones), 32'd0);
      do_op("v3", 16'h0300, 8'd9, 1'b0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
